// File: rtl/sdram_device_model_pkg.sv
// Shared types and constants for the SDR SDRAM device model:
// command encodings, error flag positions and the read-pipe stage record.
package sdram_model_pkg;

   localparam int NUM_BANKS = 4;

   localparam int ERR_NO_MODE      = 0;
   localparam int ERR_ROW_NOT_OPEN = 1;
   localparam int ERR_ROW_OPEN     = 2;
   localparam int ERR_BUS_CONFLICT = 3;

   // Encoding is {cs_n, ras_n, cas_n, we_n} with cs_n = 0
   typedef enum logic [3:0] {
      CMD_LMR       = 4'b0000,
      CMD_REFRESH   = 4'b0001,
      CMD_PRECHARGE = 4'b0010,
      CMD_ACTIVE    = 4'b0011,
      CMD_WRITE     = 4'b0100,
      CMD_READ      = 4'b0101,
      CMD_BST       = 4'b0110,
      CMD_NOP       = 4'b0111
   } cmd_t;

   typedef struct packed {
      logic        vld;
      logic [31:0] data;
      logic [3:0]  ben;
      logic [2:0]  cl;
   } rd_stage_t;

   // Deselect collapses onto NOP so the decoder only sees eight commands
   function automatic cmd_t decode_cmd(input logic cs_n, input logic ras_n,
                                       input logic cas_n, input logic we_n);
      if (cs_n) return CMD_NOP;
      return cmd_t'({1'b0, ras_n, cas_n, we_n});
   endfunction

endpackage

// File: rtl/sdram_device_model_if.sv
// Controller-to-device command/address wires of the SDRAM bus (dq travels separately as inout).
interface sdram_device_model_if;
   logic        cke;
   logic        cs_n;
   logic        ras_n;
   logic        cas_n;
   logic        we_n;
   logic [1:0]  ba;
   logic [12:0] addr;
   logic [3:0]  dqm;

   modport master (output cke, cs_n, ras_n, cas_n, we_n, ba, addr, dqm);
   modport slave  (input  cke, cs_n, ras_n, cas_n, we_n, ba, addr, dqm);
endinterface

// File: rtl/sdram_device_model_rd_pipe.sv
// Read-data delay line: each entry carries its own CAS latency so an LMR
// issued mid-flight does not retime reads already in the pipe.
module sdram_rd_pipe
   import sdram_model_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        en,
   input  logic        push,
   input  logic [31:0] push_data,
   input  logic [3:0]  push_ben,
   input  logic [2:0]  push_cl,
   output logic        drive,
   output logic [3:0]  dq_oe,
   output logic [31:0] dq_out
);

   rd_stage_t stg [3];

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 3; i++) stg[i].vld <= 1'b0;
      end else if (en) begin
         stg[0] <= '{vld: push, data: push_data, ben: push_ben, cl: push_cl};
         stg[1] <= stg[0];
         stg[2] <= stg[1];
      end
   end

   // A CL=2 read drives from stage 1, a CL=3 read from stage 2
   always_comb begin
      drive  = 1'b0;
      dq_oe  = '0;
      dq_out = '0;
      if (stg[1].vld && stg[1].cl == 3'd2) begin
         drive  = 1'b1;
         dq_oe  = stg[1].ben;
         dq_out = stg[1].data;
      end else if (stg[2].vld && stg[2].cl == 3'd3) begin
         drive  = 1'b1;
         dq_oe  = stg[2].ben;
         dq_out = stg[2].data;
      end
   end

endmodule

// File: rtl/sdram_device_model.sv
// Cycle-level SDR SDRAM device: command decode, per-bank row tracking,
// mode register, reduced-depth storage and sticky protocol-error flags.
module sdram_device_model
   import sdram_model_pkg::*;
#(
   parameter int MEM_ADDR_BITS = 12,
   parameter int COL_BITS      = 9,
   parameter int CL_DEFAULT    = 3
) (
   input  logic                clk_clk,
   input  logic                reset_reset,
   sdram_device_model_if.slave sdram_wire,
   inout  wire [31:0]          sdram_wire_dq,
   output logic [3:0]          err_flags
);

   cmd_t                     cmd;
   logic [1:0]               ba;
   logic [12:0]              addr;
   logic [NUM_BANKS-1:0]     bank_open;
   logic [12:0]              open_row [NUM_BANKS];
   logic                     mode_set;
   logic [2:0]               cl_q;
   logic [31:0]              mem [2**MEM_ADDR_BITS];
   logic [MEM_ADDR_BITS-1:0] mem_addr;
   logic [31:0]              rd_word;
   logic                     rd_drive;
   logic [3:0]               dq_oe;
   logic [31:0]              dq_out;

   assign cmd  = decode_cmd(sdram_wire.cs_n, sdram_wire.ras_n, sdram_wire.cas_n, sdram_wire.we_n);
   assign ba   = sdram_wire.ba;
   assign addr = sdram_wire.addr;

   // Flat {ba,row,col} folded onto the smaller array
   assign mem_addr = MEM_ADDR_BITS'({ba, open_row[ba], addr[COL_BITS-1:0]});
   assign rd_word  = bank_open[ba] ? mem[mem_addr] : 32'hxxxxxxxx;

   always_ff @(posedge clk_clk) begin
      if (reset_reset) begin
         bank_open <= '0;
         mode_set  <= 1'b0;
         cl_q      <= 3'(CL_DEFAULT);
         err_flags <= '0;
      end else if (sdram_wire.cke) begin
         if (!mode_set && !(cmd inside {CMD_NOP, CMD_BST, CMD_LMR}))
            err_flags[ERR_NO_MODE] <= 1'b1;
         case (cmd)
            CMD_LMR: begin
               mode_set <= 1'b1;
               if (addr[6:4] == 3'd2 || addr[6:4] == 3'd3) cl_q <= addr[6:4];
            end
            CMD_ACTIVE: begin
               if (bank_open[ba]) err_flags[ERR_ROW_OPEN] <= 1'b1;
               bank_open[ba] <= 1'b1;
            end
            CMD_PRECHARGE: begin
               if (addr[10]) bank_open <= '0;
               else          bank_open[ba] <= 1'b0;
            end
            CMD_REFRESH: begin
               if (|bank_open) err_flags[ERR_ROW_NOT_OPEN] <= 1'b1;
            end
            CMD_READ, CMD_WRITE: begin
               if (!bank_open[ba]) err_flags[ERR_ROW_NOT_OPEN] <= 1'b1;
               if (addr[10]) bank_open[ba] <= 1'b0;
               if (cmd == CMD_WRITE && rd_drive) err_flags[ERR_BUS_CONFLICT] <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   // Row addresses and storage are data, left untouched by reset
   always_ff @(posedge clk_clk) begin
      if (sdram_wire.cke && cmd == CMD_ACTIVE) open_row[ba] <= addr;
   end

   always_ff @(posedge clk_clk) begin
      if (sdram_wire.cke && cmd == CMD_WRITE && bank_open[ba]) begin
         for (int i = 0; i < 4; i++)
            if (!sdram_wire.dqm[i]) mem[mem_addr][i*8 +: 8] <= sdram_wire_dq[i*8 +: 8];
      end
   end

   sdram_rd_pipe u_rd_pipe (
      .clk       (clk_clk),
      .rst       (reset_reset),
      .en        (sdram_wire.cke),
      .push      (cmd == CMD_READ),
      .push_data (rd_word),
      .push_ben  (~sdram_wire.dqm),
      .push_cl   (cl_q),
      .drive     (rd_drive),
      .dq_oe     (dq_oe),
      .dq_out    (dq_out)
   );

   for (genvar i = 0; i < 4; i++) begin : g_dq
      assign sdram_wire_dq[i*8 +: 8] = dq_oe[i] ? dq_out[i*8 +: 8] : 8'bzzzzzzzz;
   end

endmodule

// File: tb/tb_sdram_device_model.sv
// Scoreboard bench for sdram_device_model: stimulus queues expected read words
// with their due cycle; a negedge monitor compares dq (undriven bus pulls to 0).
module tb_sdram_device_model;
   import sdram_model_pkg::*;

   typedef struct {
      int          due;
      logic [31:0] data;
      bit          care;
      string       name;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   wire  [31:0] dq;
   logic [31:0] tb_dq = '0;
   logic        tb_dq_en = 1'b0;
   logic [3:0]  err_flags;
   int          cyc = 0;
   int          last_k = 0;
   int          cur_cl = 3;
   int          errors = 0;
   int          checks = 0;
   exp_t        sb[$];

   sdram_device_model_if bus ();

   sdram_device_model dut (
      .clk_clk       (clk),
      .reset_reset   (rst),
      .sdram_wire    (bus.slave),
      .sdram_wire_dq (dq),
      .err_flags     (err_flags)
   );

   assign dq = tb_dq_en ? tb_dq : 32'hzzzzzzzz;
   for (genvar i = 0; i < 32; i++) begin : g_pd
      pulldown (dq[i]);
   end

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endfunction

   // Monitor: a due read word is compared, every other cycle dq must be released
   always @(negedge clk) begin
      exp_t e;
      while (sb.size() > 0 && sb[0].due < cyc) begin
         e = sb.pop_front();
         check({e.name, "_missed"}, 32'(e.due), 32'(cyc));
      end
      if (sb.size() > 0 && sb[0].due == cyc) begin
         e = sb.pop_front();
         if (e.care) check(e.name, dq, e.data);
      end else if (cyc > 0) begin
         check("dq_idle", dq, 32'h0);
      end
   end

   task automatic issue(input cmd_t c, input logic [1:0] ba, input logic [12:0] addr,
                        input logic [3:0] dqm, input bit drv, input logic [31:0] wdata,
                        input bit cke_v);
      @(negedge clk);
      #1;
      bus.cke   = cke_v;
      bus.cs_n  = 1'b0;
      bus.ras_n = c[2];
      bus.cas_n = c[1];
      bus.we_n  = c[0];
      bus.ba    = ba;
      bus.addr  = addr;
      bus.dqm   = dqm;
      tb_dq     = wdata;
      tb_dq_en  = drv;
      last_k    = cyc + 1;
      @(posedge clk);
      #1;
      bus.cke   = 1'b1;
      bus.cs_n  = 1'b1;
      bus.ras_n = 1'b1;
      bus.cas_n = 1'b1;
      bus.we_n  = 1'b1;
      bus.dqm   = 4'h0;
      tb_dq_en  = 1'b0;
   endtask

   task automatic lmr(input int cl, input int model_cl);
      issue(CMD_LMR, 2'd0, 13'(cl << 4), 4'h0, 1'b0, '0, 1'b1);
      cur_cl = model_cl;
   endtask

   task automatic wr(input logic [1:0] ba, input int col, input logic [3:0] dqm,
                     input bit drv, input logic [31:0] d);
      issue(CMD_WRITE, ba, 13'(col), dqm, drv, d, 1'b1);
   endtask

   task automatic rd(input logic [1:0] ba, input int col, input bit a10, input logic [3:0] dqm,
                     input logic [31:0] exp, input bit care, input bit expect_out,
                     input int extra, input string name);
      logic [12:0] a;
      a     = 13'(col);
      a[10] = a10;
      issue(CMD_READ, ba, a, dqm, 1'b0, '0, 1'b1);
      if (expect_out)
         sb.push_back('{due: last_k + cur_cl - 1 + extra, data: exp, care: care, name: name});
   endtask

   task automatic nops(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      #50000;
      $display("FAIL watchdog: simulation did not finish by %0t", $time);
      $fatal(1);
   end

   initial begin
      bus.cke = 1'b1; bus.cs_n = 1'b1; bus.ras_n = 1'b1; bus.cas_n = 1'b1; bus.we_n = 1'b1;
      bus.ba = '0; bus.addr = '0; bus.dqm = '0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      check("reset_err", 32'(err_flags), 32'h0);

      // 1: CL=3 write/read
      lmr(3, 3);
      issue(CMD_ACTIVE, 2'd0, 13'd5, 4'h0, 1'b0, '0, 1'b1);
      wr(2'd0, 4, 4'h0, 1'b1, 32'hDEADBEEF);
      rd(2'd0, 4, 1'b0, 4'h0, 32'hDEADBEEF, 1'b1, 1'b1, 0, "cl3_read");
      nops(5);

      // 2: CL=2 back-to-back reads
      lmr(2, 2);
      wr(2'd0, 0, 4'h0, 1'b1, 32'h11111111);
      wr(2'd0, 1, 4'h0, 1'b1, 32'h22222222);
      wr(2'd0, 2, 4'h0, 1'b1, 32'h33333333);
      wr(2'd0, 3, 4'h0, 1'b1, 32'h44444444);
      rd(2'd0, 0, 1'b0, 4'h0, 32'h11111111, 1'b1, 1'b1, 0, "b2b_col0");
      rd(2'd0, 1, 1'b0, 4'h0, 32'h22222222, 1'b1, 1'b1, 0, "b2b_col1");
      rd(2'd0, 2, 1'b0, 4'h0, 32'h33333333, 1'b1, 1'b1, 0, "b2b_col2");
      rd(2'd0, 3, 1'b0, 4'h0, 32'h44444444, 1'b1, 1'b1, 0, "b2b_col3");
      nops(4);

      // 3: byte masks on write and read
      wr(2'd0, 8, 4'h0, 1'b1, 32'hFFFFFFFF);
      wr(2'd0, 8, 4'b0101, 1'b1, 32'h11223344);
      rd(2'd0, 8, 1'b0, 4'h0, 32'h11FF33FF, 1'b1, 1'b1, 0, "wr_mask");
      rd(2'd0, 8, 1'b0, 4'b1000, 32'h00FF33FF, 1'b1, 1'b1, 0, "rd_mask");
      nops(4);
      check("err_clean", 32'(err_flags), 32'h0);

      // 4: protocol errors are sticky
      rd(2'd2, 0, 1'b0, 4'h0, '0, 1'b0, 1'b1, 0, "idle_bank_read");
      check("err_row_not_open", 32'(err_flags), 32'h2);
      issue(CMD_ACTIVE, 2'd1, 13'd7, 4'h0, 1'b0, '0, 1'b1);
      issue(CMD_ACTIVE, 2'd1, 13'd7, 4'h0, 1'b0, '0, 1'b1);
      check("err_row_open", 32'(err_flags), 32'h6);
      nops(4);
      check("err_sticky", 32'(err_flags), 32'h6);

      // 5: reset aborts an in-flight read, array survives
      lmr(3, 3);
      rd(2'd0, 4, 1'b0, 4'h0, '0, 1'b0, 1'b0, 0, "aborted");
      @(negedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      cur_cl = 3;
      check("err_after_reset", 32'(err_flags), 32'h0);
      nops(4);
      issue(CMD_ACTIVE, 2'd0, 13'd5, 4'h0, 1'b0, '0, 1'b1);
      check("err_no_mode", 32'(err_flags), 32'h1);
      lmr(3, 3);
      rd(2'd0, 4, 1'b0, 4'h0, 32'hDEADBEEF, 1'b1, 1'b1, 0, "read_after_reset");
      nops(5);

      // 6: cke low stretches the read latency, ignored command
      rd(2'd0, 0, 1'b0, 4'h0, 32'h11111111, 1'b1, 1'b1, 2, "cke_stall");
      issue(CMD_READ, 2'd0, 13'd1, 4'h0, 1'b0, '0, 1'b0);
      issue(CMD_READ, 2'd0, 13'd1, 4'h0, 1'b0, '0, 1'b0);
      nops(6);
      check("err_cke", 32'(err_flags), 32'h1);

      // 7: bus conflict only when write meets driven read data
      lmr(2, 2);
      rd(2'd0, 4, 1'b0, 4'h0, 32'hDEADBEEF, 1'b1, 1'b1, 0, "pre_conflict");
      wr(2'd0, 4, 4'hF, 1'b0, '0);
      check("no_conflict", 32'(err_flags), 32'h1);
      rd(2'd0, 4, 1'b0, 4'h0, 32'hDEADBEEF, 1'b1, 1'b1, 0, "conflict_read");
      nops(1);
      wr(2'd0, 4, 4'hF, 1'b0, '0);
      check("bus_conflict", 32'(err_flags), 32'h9);
      nops(3);

      // 8: auto-precharge, refresh and precharge-all
      rd(2'd0, 4, 1'b1, 4'h0, 32'hDEADBEEF, 1'b1, 1'b1, 0, "auto_pre_read");
      issue(CMD_ACTIVE, 2'd0, 13'd5, 4'h0, 1'b0, '0, 1'b1);
      check("auto_precharge", 32'(err_flags), 32'h9);
      issue(CMD_REFRESH, 2'd0, 13'd0, 4'h0, 1'b0, '0, 1'b1);
      check("refresh_open", 32'(err_flags), 32'hB);
      issue(CMD_PRECHARGE, 2'd3, 13'h400, 4'h0, 1'b0, '0, 1'b1);
      issue(CMD_ACTIVE, 2'd0, 13'd5, 4'h0, 1'b0, '0, 1'b1);
      check("precharge_all", 32'(err_flags), 32'hB);
      nops(6);

      check("sb_drained", 32'(sb.size()), 32'h0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
